// File: rtl/sll_seq_if.sv
// sll_seq_if: handshake and data bundle for the sequential logical left shifter.
//
// Signals
//   in_valid   source -> shifter   operand pair offered
//   in_ready   shifter -> source   shifter idle and able to take an operand pair
//   data       source -> shifter   value to shift (WIDTH bits)
//   shiftamt   source -> shifter   shift amount, 0..WIDTH-1 (SHAMT_W bits)
//   out_valid  shifter -> sink     result/lost valid, held until accepted
//   out_ready  sink -> shifter     sink accepts the result
//   result     shifter -> sink     data << shiftamt, zero-filled
//   lost       shifter -> sink     a 1 bit was shifted out past the MSB
//
// Modports
//   master  the side that offers operands and consumes results
//   slave   the shifter itself
interface sll_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shiftamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               lost;

    modport master (
        output in_valid,
        output data,
        output shiftamt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  lost
    );

    modport slave (
        input  in_valid,
        input  data,
        input  shiftamt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output lost
    );
endinterface

// File: rtl/sll_seq.sv
// sll_seq: multi-cycle logical left shifter, a shared shift resource placed
// beside the ALU. One barrel stage is applied per cycle, largest stage first
// (2**(SHAMT_W-1) down to 1), so every operation takes exactly SHAMT_W shift
// cycles whatever the shift amount. Any 1 bit pushed past the MSB sets 'lost'.
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous, active-low reset; discards any operation in flight
//   bus      slave modport of sll_seq_if (valid/ready in, valid/ready out,
//            data, shiftamt, result, lost)
//
// Parameters
//   WIDTH    data width, must equal 2**SHAMT_W
//   SHAMT_W  shift-amount width, also the number of shift cycles
module sll_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    sll_seq_if.slave   bus
);

    // Stage counter only needs to index the bits of the shift amount.
    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] amt;
    logic [CNT_W-1:0]   count;
    logic               lost_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [SHAMT_W-1:0] stage_dist;
    logic [WIDTH-1:0]   spill_mask;
    logic [WIDTH-1:0]   work_next;
    logic               spill;

    // The current stage moves the word by 2**count when the matching
    // amount bit is set. The bits that fall off are exactly the top
    // stage_dist bits of the working word, selected by spill_mask.
    always_comb begin
        stage_dist = SHAMT_W'(1) << count;
        spill_mask = ~({WIDTH{1'b1}} >> stage_dist);
        work_next  = work;
        spill      = 1'b0;
        if (amt[count]) begin
            work_next = work << stage_dist;
            spill     = |(work & spill_mask);
        end
    end

    // Control FSM with registered handshake outputs. The working register
    // doubles as the result register, so result is only meaningful while
    // out_valid is high and stays put until the next operand is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            work        <= '0;
            amt         <= '0;
            count       <= '0;
            lost_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.data;
                        amt        <= bus.shiftamt;
                        lost_q     <= 1'b0;
                        count      <= CNT_W'(SHAMT_W - 1);
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    work   <= work_next;
                    lost_q <= lost_q | spill;
                    if (count == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    // in_ready stays low here, so a new operand can only be
                    // taken one cycle after the result is consumed.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = work;
    assign bus.lost      = lost_q;

endmodule

// File: tb/tb_sll_seq.sv
// tb_sll_seq: self-checking bench for sll_seq. Directed vectors from a table,
// hand-written sequences for reset, backpressure and back-to-back operation,
// and a short run of random operands checked against a wide-shift reference.
module tb_sll_seq;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int LAT     = SHAMT_W;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    sll_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    sll_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp_result;
        logic        exp_lost;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer an operand at a falling edge, wait for the accepting rising edge,
    // then scramble the inputs to show they no longer matter.
    task automatic send(input logic [31:0] d, input logic [4:0] a);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check_output("in_ready timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.data     = d;
        bus.shiftamt = a;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.data     = ~d;
        bus.shiftamt = ~a;
        check_output("in_ready low after accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!bus.out_valid) check_output("out_valid timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [31:0] d, input logic [4:0] a, output int lat);
        send(d, a);
        wait_result(lat);
    endtask

    task automatic complete_handshake();
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check_output("out_valid low after accept", 32'(bus.out_valid), 32'd0);
        check_output("in_ready high after accept", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        logic [4:0]  a;
        logic [63:0] wide;

        tests = 0;
        fails = 0;

        vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b1};
        vecs[2] = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
        vecs[3] = '{32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A, 1'b1};
        vecs[4] = '{32'h0000_01FF, 5'd24, 32'hFF00_0000, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b0};
        vecs[6] = '{32'h8000_0000, 5'd31, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.shiftamt  = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset result", bus.result, 32'd0);
        check_output("reset lost", 32'(bus.lost), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_output("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].amt, lat);
            check_output($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            check_output($sformatf("vec%0d result", i), bus.result, vecs[i].exp_result);
            check_output($sformatf("vec%0d lost", i), 32'(bus.lost), 32'(vecs[i].exp_lost));
            complete_handshake();
        end

        // Reset asserted in the middle of a shift
        send(32'hFFFF_FFFF, 5'd7);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_output("midshift reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("midshift reset result", bus.result, 32'd0);
        check_output("midshift reset lost", 32'(bus.lost), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_output("midshift reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        check_output("post reset idle out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: result held for 10 cycles, a new operand is ignored
        apply_stimulus(32'h0000_00FF, 5'd8, lat);
        check_output("bp latency", 32'(lat), 32'(LAT));
        bus.in_valid = 1'b1;
        bus.data     = 32'hDEAD_BEEF;
        bus.shiftamt = 5'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check_output($sformatf("bp out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("bp result c%0d", c), bus.result, 32'h0000_FF00);
            check_output($sformatf("bp in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
        end
        check_output("bp lost", 32'(bus.lost), 32'd0);
        bus.in_valid = 1'b0;
        complete_handshake();

        // Back-to-back: the second operand is held from the start and must
        // only be taken the cycle after the first result is consumed.
        send(32'hFFFF_FFFF, 5'd16);
        bus.in_valid = 1'b1;
        bus.data     = 32'h0000_FFFF;
        bus.shiftamt = 5'd16;
        wait_result(lat);
        check_output("b2b first latency", 32'(lat), 32'(LAT));
        check_output("b2b first result", bus.result, 32'hFFFF_0000);
        check_output("b2b first lost", 32'(bus.lost), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check_output("b2b idle in_ready", 32'(bus.in_ready), 32'd1);
        check_output("b2b idle out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        check_output("b2b second accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_result(lat);
        check_output("b2b second latency", 32'(lat), 32'(LAT));
        check_output("b2b second result", bus.result, 32'hFFFF_0000);
        check_output("b2b second lost", 32'(bus.lost), 32'd0);
        complete_handshake();

        // Random operands against a double-width reference shift
        for (int r = 0; r < 20; r++) begin
            d    = $urandom;
            a    = 5'($urandom_range(0, 31));
            wide = {32'd0, d} << a;
            apply_stimulus(d, a, lat);
            check_output($sformatf("rand%0d result", r), bus.result, wide[31:0]);
            check_output($sformatf("rand%0d lost", r), 32'(bus.lost), 32'(|wide[63:32]));
            complete_handshake();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
